debounce_fsm: RTL and testbench

- Control stage paired with the continuous stability counter, which is instantiated beside it at top level.
- Synchronises one asynchronous input (button/switch). Drives the counter's increment-enable while the input holds a candidate level, and consumes the counter's threshold tick to commit that level.
- Outputs a clean debounced level, one-cycle rise/fall pulses and a wrapping press count for downstream logic.

---
 rtl/debounce_fsm_pkg.sv | 25 ++
 rtl/debounce_fsm_sync_ff_chain.sv | 29 ++
 rtl/debounce_fsm.sv | 122 ++++++++++++
 tb/tb_debounce_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_fsm_pkg.sv
// Shared definitions for the debounce controller: state encodings,
// default synchroniser depth and a helper mapping a level to its stable state.
package debounce_fsm_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'd0,
        ST_WAIT_HIGH   = 2'd1,
        ST_STABLE_HIGH = 2'd2,
        ST_WAIT_LOW    = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Stable state that corresponds to a given debounced level.
    function automatic state_t stable_state_for(input logic level);
        state_t s;
        if (level) begin
            s = ST_STABLE_HIGH;
        end else begin
            s = ST_STABLE_LOW;
        end
        return s;
    endfunction

endpackage

// File: rtl/debounce_fsm_sync_ff_chain.sv
// Multi-flop synchroniser for one asynchronous level. The chain resets to
// INIT_LEVEL so that the first cycles after reset do not look like an edge.
// SYNC_STAGES is intended to lie in 2..4.
module sync_ff_chain
    import debounce_fsm_pkg::*;
#(
    parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw level through the chain; stage 0 is the metastability catcher.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Debounce control stage. Works with an external stability counter: while
// the synchronised input holds a candidate level the counter is told to keep
// counting, and the counter's threshold tick commits that level.
module debounce_fsm
    import debounce_fsm_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter logic INIT_LEVEL      = 1'b0,
    parameter int   PRESS_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       btn_raw,
    output logic                       ctrl_inc,
    input  logic                       tick,
    output logic                       db_level,
    output logic                       rise_pulse,
    output logic                       fall_pulse,
    output logic [PRESS_CNT_WIDTH-1:0] press_count
);

    logic                       w_sync_in;
    logic                       w_ctrl_inc;
    state_t                     r_state;
    logic                       r_db_level;
    logic                       r_rise_pulse;
    logic                       r_fall_pulse;
    logic [PRESS_CNT_WIDTH-1:0] r_press_count;

    sync_ff_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .INIT_LEVEL  (INIT_LEVEL)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (btn_raw),
        .o_q     (w_sync_in)
    );

    // Counter enable: count only while a WAIT state still sees its candidate
    // level. Any STABLE cycle drives 0, so the counter is already cleared on
    // the edge that enters a WAIT state.
    always_comb begin
        w_ctrl_inc = 1'b0;
        case (r_state)
            ST_WAIT_HIGH: begin
                if (w_sync_in) begin
                    w_ctrl_inc = 1'b1;
                end else begin
                    w_ctrl_inc = 1'b0;
                end
            end
            ST_WAIT_LOW: begin
                if (!w_sync_in) begin
                    w_ctrl_inc = 1'b1;
                end else begin
                    w_ctrl_inc = 1'b0;
                end
            end
            default: begin
                w_ctrl_inc = 1'b0;
            end
        endcase
    end

    // Debounce state machine with registered level, edge pulses and press count.
    // A mismatching input wins over a simultaneous tick (abort before commit).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= stable_state_for(INIT_LEVEL);
            r_db_level    <= INIT_LEVEL;
            r_rise_pulse  <= 1'b0;
            r_fall_pulse  <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
            case (r_state)
                ST_STABLE_LOW: begin
                    if (w_sync_in) begin
                        r_state <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!w_sync_in) begin
                        r_state <= ST_STABLE_LOW;
                    end else if (tick) begin
                        r_state       <= ST_STABLE_HIGH;
                        r_db_level    <= 1'b1;
                        r_rise_pulse  <= 1'b1;
                        r_press_count <= r_press_count + PRESS_CNT_WIDTH'(1);
                    end
                end
                ST_STABLE_HIGH: begin
                    if (!w_sync_in) begin
                        r_state <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (w_sync_in) begin
                        r_state <= ST_STABLE_HIGH;
                    end else if (tick) begin
                        r_state      <= ST_STABLE_LOW;
                        r_db_level   <= 1'b0;
                        r_fall_pulse <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= stable_state_for(INIT_LEVEL);
                    r_db_level <= INIT_LEVEL;
                end
            endcase
        end
    end

    assign ctrl_inc    = w_ctrl_inc;
    assign db_level    = r_db_level;
    assign rise_pulse  = r_rise_pulse;
    assign fall_pulse  = r_fall_pulse;
    assign press_count = r_press_count;

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm with a behavioural stability counter (T = 10) and a
// run-length reference model: a level is committed once the synchronised
// input has differed from the debounced level for T+2 consecutive cycles.
module tb_debounce_fsm;

    localparam int SYNC = 2;
    localparam int T    = 10;
    localparam int PW   = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          btn_raw = 1'b0;
    logic          ctrl_inc;
    logic          tick;
    logic          db_level;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [PW-1:0] press_count;

    logic [7:0]    cnt;
    logic          force_tick = 1'b0;

    // Reference model state
    logic [SYNC-1:0] m_hist;
    logic            m_db;
    int              m_run;
    logic            m_rise;
    logic            m_fall;
    logic [PW-1:0]   m_press;
    logic            m_sync;
    logic            m_inc;

    int total = 0;
    int bad   = 0;

    debounce_fsm #(
        .SYNC_STAGES     (SYNC),
        .INIT_LEVEL      (1'b0),
        .PRESS_CNT_WIDTH (PW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .ctrl_inc    (ctrl_inc),
        .tick        (tick),
        .db_level    (db_level),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    // Stability counter: counts while enabled, clears otherwise, holds at T.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 8'd0;
        end else if (ctrl_inc) begin
            if (cnt != 8'(T)) cnt <= cnt + 8'd1;
        end else begin
            cnt <= 8'd0;
        end
    end

    assign m_sync = m_hist[SYNC-1];
    // Forced tick only ever appears while the input sits at the debounced level.
    assign tick   = (cnt == 8'(T)) | (force_tick & (m_sync == m_db));
    // Counter enable expected: a candidate run is in progress and still holds.
    assign m_inc  = (m_run >= 1) && (m_sync != m_db);

    // Reference model: mismatch run length against the debounced level.
    always @(posedge clk or negedge reset_n) begin : model
        int   rv;
        logic dbv, rs, fs;
        logic [PW-1:0] pv;
        if (!reset_n) begin
            m_hist <= '0; m_db <= 1'b0; m_run <= 0;
            m_rise <= 1'b0; m_fall <= 1'b0; m_press <= '0;
        end else begin
            dbv = m_db; rs = 1'b0; fs = 1'b0; pv = m_press;
            if (m_sync != m_db) rv = m_run + 1;
            else rv = 0;
            if (rv == T + 2) begin
                dbv = m_sync; rv = 0;
                if (m_sync) begin rs = 1'b1; pv = m_press + 1'b1; end
                else fs = 1'b1;
            end
            m_run <= rv; m_db <= dbv; m_rise <= rs; m_fall <= fs; m_press <= pv;
            m_hist <= {m_hist[SYNC-2:0], btn_raw};
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({db_level, rise_pulse, fall_pulse, ctrl_inc} !== 4'b0000 || press_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_hold: db=%b rise=%b fall=%b inc=%b press=%0d required all 0",
                     db_level, rise_pulse, fall_pulse, ctrl_inc, press_count);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            total++;
            if ({db_level, rise_pulse, fall_pulse, ctrl_inc} !== 4'b0000 || press_count !== 8'd0) begin
                bad++;
                $display("FAIL reset_idle cyc %0d: db=%b rise=%b fall=%b inc=%b press=%0d required all 0",
                         i, db_level, rise_pulse, fall_pulse, ctrl_inc, press_count);
            end
        end
    endtask

    task automatic test_glitch();
        int saw_inc = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (ctrl_inc) saw_inc++;
            total++;
            if (db_level !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 || ctrl_inc !== m_inc) begin
                bad++;
                $display("FAIL glitch cyc %0d: db=%b rise=%b fall=%b inc=%b required db=0 no pulse inc=%b",
                         i, db_level, rise_pulse, fall_pulse, ctrl_inc, m_inc);
            end
            if (i == 4) btn_raw = 1'b0;
        end
        total++;
        if (saw_inc == 0 || ctrl_inc !== 1'b0 || cnt !== 8'd0) begin
            bad++;
            $display("FAIL glitch_end: inc_cycles=%0d inc=%b cnt=%0d required >0, 0, 0", saw_inc, ctrl_inc, cnt);
        end
    endtask

    task automatic test_edge(input logic lvl, input logic [PW-1:0] exp_press);
        int first = 0;
        int pulses = 0;
        int wrong = 0;
        btn_raw = lvl;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (db_level === lvl && first == 0) first = i;
            if (lvl ? rise_pulse : fall_pulse) pulses++;
            if (lvl ? fall_pulse : rise_pulse) wrong++;
            total++;
            if (db_level !== m_db || rise_pulse !== m_rise || fall_pulse !== m_fall) begin
                bad++;
                $display("FAIL edge%b cyc %0d: db=%b rise=%b fall=%b required %b %b %b",
                         lvl, i, db_level, rise_pulse, fall_pulse, m_db, m_rise, m_fall);
            end
        end
        total++;
        if (first != SYNC + 1 + T + 1 || pulses != 1 || wrong != 0 || press_count !== exp_press) begin
            bad++;
            $display("FAIL edge%b_summary: latency=%0d pulses=%0d other=%0d press=%0d required %0d 1 0 %0d",
                     lvl, first, pulses, wrong, press_count, SYNC + 1 + T + 1, exp_press);
        end
    endtask

    task automatic test_tick_abort();
        btn_raw = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if (db_level !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 || ctrl_inc !== m_inc) begin
                bad++;
                $display("FAIL tick_abort cyc %0d: db=%b rise=%b fall=%b inc=%b required 0 0 0 %b",
                         i, db_level, rise_pulse, fall_pulse, ctrl_inc, m_inc);
            end
            if (i == 5) begin btn_raw = 1'b0; force_tick = 1'b1; end
            if (i == 20) force_tick = 1'b0;
        end
    endtask

    task automatic test_reset_mid_wait();
        btn_raw = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (ctrl_inc !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait_inc: inc=%b required 1", ctrl_inc);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({db_level, rise_pulse, fall_pulse, ctrl_inc} !== 4'b0000 || press_count !== 8'd0 || cnt !== 8'd0) begin
            bad++;
            $display("FAIL mid_wait_reset: db=%b rise=%b fall=%b inc=%b press=%0d cnt=%0d required all 0",
                     db_level, rise_pulse, fall_pulse, ctrl_inc, press_count, cnt);
        end
        btn_raw = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_wrap();
        int rises = 0;
        for (int p = 0; p < 256; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                int h = $urandom_range(14, 20);
                btn_raw = (ph == 0);
                for (int c = 0; c < h; c++) begin
                    @(negedge clk);
                    if (rise_pulse) rises++;
                    total++;
                    if (press_count !== m_press || rise_pulse !== m_rise || db_level !== m_db) begin
                        bad++;
                        $display("FAIL wrap press %0d: press=%0d rise=%b db=%b required %0d %b %b",
                                 p, press_count, rise_pulse, db_level, m_press, m_rise, m_db);
                    end
                end
            end
        end
        repeat (20) @(negedge clk);
        total++;
        if (rises != 256 || press_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap_end: rises=%0d press=%0d required 256 0", rises, press_count);
        end
    endtask

    task automatic test_random();
        int left = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            total++;
            if (db_level !== m_db || rise_pulse !== m_rise || fall_pulse !== m_fall ||
                press_count !== m_press || ctrl_inc !== m_inc) begin
                bad++;
                $display("FAIL random cyc %0d: db=%b rise=%b fall=%b press=%0d inc=%b required %b %b %b %0d %b",
                         i, db_level, rise_pulse, fall_pulse, press_count, ctrl_inc,
                         m_db, m_rise, m_fall, m_press, m_inc);
            end
            if (left == 0) begin
                btn_raw = ~btn_raw;
                left = $urandom_range(1, 18);
            end else begin
                left--;
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_edge(1'b1, 8'd1);
        test_edge(1'b0, 8'd1);
        test_tick_abort();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
